// File: rtl/fft_power_spectrum_if.sv
// Handshake and RAM-port bundle between the power-spectrum stage, its
// control logic and the FFT / power-spectrum RAMs.
interface fft_power_spectrum_if #(
    parameter int N = 32
);
    logic         start;
    logic [8:0]   addr_fft_re;
    logic [8:0]   addr_fft_im;
    logic [N-1:0] fft_re;
    logic [N-1:0] fft_im;
    logic [8:0]   addr_sw;
    logic [N-1:0] data_sw;
    logic         wren_sw;
    logic [8:0]   peak_bin;
    logic [N-1:0] peak_val;
    logic         busy;
    logic         done;

    modport master (
        output start, fft_re, fft_im,
        input  addr_fft_re, addr_fft_im, addr_sw, data_sw, wren_sw,
               peak_bin, peak_val, busy, done
    );

    modport slave (
        input  start, fft_re, fft_im,
        output addr_fft_re, addr_fft_im, addr_sw, data_sw, wren_sw,
               peak_bin, peak_val, busy, done
    );
endinterface

// File: rtl/fft_power_spectrum.sv
// Sweeps the FFT output bins, writes |X[b]|^2 (Q16.16 sign-magnitude, saturating)
// to the power RAM and tracks the strongest bin for the pitch search.
module fft_power_spectrum #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int NBINS = 512
) (
    input logic                clk,
    input logic                rst,
    fft_power_spectrum_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT    = 4'd1,
        RD_ADDR = 4'd2,
        WAIT1   = 4'd3,
        WAIT2   = 4'd4,
        SQUARE  = 4'd5,
        SUM     = 4'd6,
        WRITE   = 4'd7,
        NEXT    = 4'd8,
        DONE    = 4'd9
    } state_t;

    localparam logic [N-1:0] SAT_VAL  = {1'b0, {(N-1){1'b1}}};
    localparam logic [9:0]   LAST_BIN = 10'(NBINS - 1);

    // Square of the magnitude, rescaled by Q and clamped to the largest positive word.
    function automatic logic [N-1:0] sq_sat(input logic [N-1:0] x);
        logic [2*N-3:0] prod;
        logic [2*N-3:0] scaled;
        prod   = {{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, x[N-2:0]};
        scaled = prod >> Q;
        if (|scaled[2*N-3:N-1]) begin
            return SAT_VAL;
        end else begin
            return {1'b0, scaled[N-2:0]};
        end
    endfunction

    // Both addends are non-negative, so any carry into the sign bit is an overflow.
    function automatic logic [N-1:0] sum_sat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a + b;
        if (s[N-1]) begin
            return SAT_VAL;
        end else begin
            return s;
        end
    endfunction

    state_t       state_r;
    state_t       state_next_s;
    logic [9:0]   bin_r;
    logic [N-1:0] sq_re_r;
    logic [N-1:0] sq_im_r;
    logic [N-1:0] pwr_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: seven states per bin, RD_ADDR through NEXT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = INIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            INIT:    state_next_s = RD_ADDR;
            RD_ADDR: state_next_s = WAIT1;
            WAIT1:   state_next_s = WAIT2;
            WAIT2:   state_next_s = SQUARE;
            SQUARE:  state_next_s = SUM;
            SUM:     state_next_s = WRITE;
            WRITE:   state_next_s = NEXT;
            NEXT: begin
                if (bin_r == LAST_BIN) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RD_ADDR;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; each state's action lands on the edge leaving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r           <= 10'd0;
            sq_re_r         <= '0;
            sq_im_r         <= '0;
            pwr_r           <= '0;
            bus.addr_fft_re <= 9'd0;
            bus.addr_fft_im <= 9'd0;
            bus.addr_sw     <= 9'd0;
            bus.data_sw     <= '0;
            bus.wren_sw     <= 1'b0;
            bus.peak_bin    <= 9'd0;
            bus.peak_val    <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.wren_sw <= 1'b0;
            bus.done    <= 1'b0;
            case (state_r)
                INIT: begin
                    bin_r        <= 10'd0;
                    bus.peak_val <= '0;
                    bus.peak_bin <= 9'd0;
                    bus.busy     <= 1'b1;
                end
                RD_ADDR: begin
                    bus.addr_fft_re <= bin_r[8:0];
                    bus.addr_fft_im <= bin_r[8:0];
                end
                SQUARE: begin
                    sq_re_r <= sq_sat(bus.fft_re);
                    sq_im_r <= sq_sat(bus.fft_im);
                end
                SUM: begin
                    pwr_r <= sum_sat(sq_re_r, sq_im_r);
                end
                WRITE: begin
                    bus.addr_sw <= bin_r[8:0];
                    bus.data_sw <= pwr_r;
                    bus.wren_sw <= 1'b1;
                    // Strict compare keeps the lowest index on ties.
                    if (pwr_r > bus.peak_val) begin
                        bus.peak_val <= pwr_r;
                        bus.peak_bin <= bin_r[8:0];
                    end
                end
                NEXT: begin
                    if (bin_r != LAST_BIN) begin
                        bin_r <= bin_r + 10'd1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Directed bench for fft_power_spectrum: RAM model with 2-cycle read latency,
// write logger, and hand-computed expectations for power, peak and timing.
module tb_fft_power_spectrum;

    localparam int N     = 32;
    localparam int NBINS = 512;
    localparam int LOGSZ = 8192;

    logic clk;
    logic rst;

    fft_power_spectrum_if #(.N(N)) bus ();

    fft_power_spectrum #(.N(N), .Q(16), .NBINS(NBINS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] re_mem [0:NBINS-1];
    logic [N-1:0] im_mem [0:NBINS-1];
    logic [N-1:0] rd_re;
    logic [N-1:0] rd_im;

    int log_addr [0:LOGSZ-1];
    int log_data [0:LOGSZ-1];
    int wr_total;
    int done_total;
    int sweep_base;
    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FFT RAMs: address registered, data available two edges later.
    always @(posedge clk) begin
        rd_re      <= re_mem[bus.addr_fft_re];
        rd_im      <= im_mem[bus.addr_fft_im];
        bus.fft_re <= rd_re;
        bus.fft_im <= rd_im;
    end

    // Log every power-RAM write and every done pulse.
    always @(negedge clk) begin
        if (bus.wren_sw && wr_total < LOGSZ) begin
            log_addr[wr_total] <= int'(bus.addr_sw);
            log_data[wr_total] <= int'(bus.data_sw);
            wr_total           <= wr_total + 1;
        end
        if (bus.done) begin
            done_total <= done_total + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NBINS; i++) begin
            re_mem[i] = 32'h0;
            im_mem[i] = 32'h0;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_wren"}, 64'(bus.wren_sw), 64'd0);
        check({tag, "_pbin"}, 64'(bus.peak_bin), 64'd0);
        check({tag, "_pval"}, 64'(bus.peak_val), 64'd0);
        check({tag, "_data"}, 64'(bus.data_sw), 64'd0);
        check({tag, "_addr"}, 64'(bus.addr_fft_re), 64'd0);
    endtask

    // One full sweep: start, optional extra start pulse at edge pulse_at, timing/order checks.
    task automatic run_sweep(input string tag, input int pulse_at);
        int done_edge;
        int done_base;
        int bad;
        sweep_base = wr_total;
        done_base  = done_total;
        done_edge  = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 6000; k++) begin
            @(negedge clk);
            bus.start = (k == pulse_at);
            if (bus.done) begin
                done_edge = k;
                break;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_edge"}, 64'(done_edge), 64'd3586);
        repeat (3) @(negedge clk);
        check({tag, "_wr_count"}, 64'(wr_total - sweep_base), 64'd512);
        check({tag, "_done_pulses"}, 64'(done_total - done_base), 64'd1);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
        bad = 0;
        for (int i = 0; i < NBINS; i++) begin
            if (log_addr[sweep_base + i] != i) bad++;
        end
        check({tag, "_wr_order"}, 64'(bad), 64'd0);
    endtask

    function automatic logic [31:0] sw_at(input int b);
        return 32'(log_data[sweep_base + b]);
    endfunction

    initial begin
        int snap;
        int base;
        int found;
        int nz;
        checks     = 0;
        errors     = 0;
        wr_total   = 0;
        done_total = 0;
        sweep_base = 0;
        rd_re      = 32'h0;
        rd_im      = 32'h0;
        clear_mem();
        rst        = 1'b1;
        bus.start  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single bin 3+4j.
        clear_mem();
        re_mem[5] = 32'h0003_0000;
        im_mem[5] = 32'h0004_0000;
        run_sweep("pos", 0);
        check("pos_sw5", 64'(sw_at(5)), 64'h0019_0000);
        check("pos_pbin", 64'(bus.peak_bin), 64'd5);
        check("pos_pval", 64'(bus.peak_val), 64'h0019_0000);

        // Sign handling, square/sum saturation, fractions, peak tie with saturated bins.
        clear_mem();
        re_mem[9]  = 32'h8003_0000;
        im_mem[9]  = 32'h8004_0000;
        re_mem[2]  = 32'h0100_0000;
        re_mem[30] = 32'h0080_0000;
        im_mem[30] = 32'h8080_0000;
        re_mem[40] = 32'h0000_8000;
        run_sweep("mix", 0);
        check("mix_sw9", 64'(sw_at(9)), 64'h0019_0000);
        check("mix_sw2", 64'(sw_at(2)), 64'h7FFF_FFFF);
        check("mix_sw30", 64'(sw_at(30)), 64'h7FFF_FFFF);
        check("mix_sw40", 64'(sw_at(40)), 64'h0000_4000);
        nz = 0;
        for (int i = 0; i < NBINS; i++) begin
            if (sw_at(i) != 32'h0) nz++;
        end
        check("mix_nonzero", 64'(nz), 64'd4);
        check("mix_pbin", 64'(bus.peak_bin), 64'd2);
        check("mix_pval", 64'(bus.peak_val), 64'h7FFF_FFFF);

        // Equal power in bins 10 and 20: lower index wins.
        clear_mem();
        re_mem[10] = 32'h0001_0000;
        im_mem[20] = 32'h8001_0000;
        run_sweep("tie", 0);
        check("tie_sw10", 64'(sw_at(10)), 64'h0001_0000);
        check("tie_sw20", 64'(sw_at(20)), 64'h0001_0000);
        check("tie_pbin", 64'(bus.peak_bin), 64'd10);
        check("tie_pval", 64'(bus.peak_val), 64'h0001_0000);

        // All-zero spectrum.
        clear_mem();
        run_sweep("zero", 0);
        check("zero_pbin", 64'(bus.peak_bin), 64'd0);
        check("zero_pval", 64'(bus.peak_val), 64'd0);

        // Reset during bin 100, then a fresh sweep.
        re_mem[7] = 32'h0002_0000;
        base = wr_total;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.busy && bus.addr_fft_re == 9'd100) begin
                found = 1;
                break;
            end
        end
        check("rst_reach_bin100", 64'(found), 64'd1);
        #1 rst = 1'b1;
        snap = wr_total;
        check("rst_partial_writes", 64'(snap - base), 64'd100);
        @(negedge clk);
        check_idle_zero("rst_mid");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_writes", 64'(wr_total - snap), 64'd0);
        check("rst_busy_low", 64'(bus.busy), 64'd0);
        run_sweep("restart", 0);
        check("restart_sw7", 64'(sw_at(7)), 64'h0004_0000);
        check("restart_pbin", 64'(bus.peak_bin), 64'd7);

        // Extra start pulse in the middle of a sweep is ignored.
        run_sweep("busy_start", 350);
        repeat (10) @(negedge clk);
        check("busy_start_idle", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
